parametric_count_connected_core: RTL

PARAMETRIC_COUNT_CONNECTED_CORE -- requirements
Module: parametricCountConnectedCore

---
 rtl/parametric_count_connected_core_pkg.sv | 32 +++
 rtl/parametric_count_connected_core_monotonize.sv | 36 +++
 rtl/parametric_count_connected_core.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/parametric_count_connected_core_pkg.sv
// Shared definitions for the connected-component counter: FSM states,
// graph width derivation and the subset/superset neighbour helpers used
// by the monotonizing networks.
package parametric_count_connected_core_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEED   = 2'd1,
    EXPAND = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  // Network direction: UP closes a set towards supersets, DOWN towards subsets.
  localparam bit DIR_UP   = 1'b0;
  localparam bit DIR_DOWN = 1'b1;

  // One graph bit per subset of the variables.
  function automatic int graphBitsOf(input int variables);
    return 1 << variables;
  endfunction

  // Index k with variable v removed: a subset of k (equals k when v is absent).
  function automatic int subsetNeighbour(input int k, input int v);
    return k & ~(1 << v);
  endfunction

  // Index k with variable v added: a superset of k (equals k when v is present).
  function automatic int supersetNeighbour(input int k, input int v);
    return k | (1 << v);
  endfunction

endpackage

// File: rtl/parametric_count_connected_core_monotonize.sv
// Monotone closure of a set-indexed bit vector over the subset lattice.
// UP:   y[k] = OR of x[j] over all subsets j of k.
// DOWN: y[k] = OR of x[j] over all supersets j of k.
// Built as VARIABLES layers; layer v folds in the neighbour differing in
// variable v, so after all layers every chain of single-variable steps is
// covered. Purely combinational.
module monotonizeNetwork
  import parametric_count_connected_core_pkg::*;
#(
  parameter int VARIABLES = 7,
  parameter bit DIRECTION = DIR_UP,
  localparam int GRAPH_BITS = graphBitsOf(VARIABLES)
) (
  input  logic [GRAPH_BITS-1:0] x,
  output logic [GRAPH_BITS-1:0] y
);

  logic [VARIABLES:0][GRAPH_BITS-1:0] stage;

  assign stage[0] = x;

  for (genvar v = 0; v < VARIABLES; v++) begin : gLayer
    for (genvar k = 0; k < GRAPH_BITS; k++) begin : gBit
      localparam int P = (DIRECTION == DIR_UP) ? subsetNeighbour(k, v)
                                               : supersetNeighbour(k, v);
      if (P != k) begin : gFold
        assign stage[v+1][k] = stage[v][k] | stage[v][P];
      end else begin : gPass
        assign stage[v+1][k] = stage[v][k];
      end
    end
  end

  assign y = stage[VARIABLES];

endmodule

// File: rtl/parametric_count_connected_core.sv
// Counts connected components of a set-indexed graph. Two present subsets
// are adjacent when some member of the bound topIn contains both. Each
// component is found by seeding from the lowest remaining subset and
// expanding one frontier step per cycle until it stops growing.
module parametric_count_connected_core
  import parametric_count_connected_core_pkg::*;
#(
  parameter int VARIABLES        = 7,
  parameter int COUNT_WIDTH      = 6,
  parameter int EXTRA_DATA_WIDTH = 10,
  localparam int GRAPH_BITS      = graphBitsOf(VARIABLES)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [GRAPH_BITS-1:0]       graphIn,
  input  logic [GRAPH_BITS-1:0]       topIn,
  input  logic [EXTRA_DATA_WIDTH-1:0] extraDataIn,
  input  logic                        inValid,
  output logic                        inReady,
  output logic                        outValid,
  input  logic                        outReady,
  output logic [COUNT_WIDTH-1:0]      connectCountOut,
  output logic                        overflowOut,
  output logic [EXTRA_DATA_WIDTH-1:0] extraDataOut,
  output logic                        busy
);

  state_t                        state;
  logic [GRAPH_BITS-1:0]         leftNodes;   // subsets not yet assigned to a component
  logic [GRAPH_BITS-1:0]         compNodes;   // component currently being grown
  logic [GRAPH_BITS-1:0]         topBound;
  logic [EXTRA_DATA_WIDTH-1:0]   tag;
  logic [COUNT_WIDTH-1:0]        count;
  logic                          overflow;

  logic [GRAPH_BITS-1:0]         seedBit;
  logic [GRAPH_BITS-1:0]         upClosure;
  logic [GRAPH_BITS-1:0]         downClosure;
  logic [GRAPH_BITS-1:0]         newNodes;
  logic [GRAPH_BITS-1:0]         remaining;
  logic [COUNT_WIDTH:0]          countNext;

  // Count step that sticks at all-ones and flags the increment it dropped.
  function automatic logic [COUNT_WIDTH:0] satIncrement(
    input logic [COUNT_WIDTH-1:0] cnt,
    input logic                   ovf
  );
    if (&cnt) return {1'b1, cnt};
    return {ovf, cnt + COUNT_WIDTH'(1)};
  endfunction

  // Isolates the lowest set bit (two's-complement trick).
  function automatic logic [GRAPH_BITS-1:0] lowestSetBit(
    input logic [GRAPH_BITS-1:0] vec
  );
    return vec & (~vec + GRAPH_BITS'(1));
  endfunction

  // Frontier: remaining subsets that share a containing bound member with
  // some subset of the current component.
  monotonizeNetwork #(
    .VARIABLES (VARIABLES),
    .DIRECTION (DIR_UP)
  ) upNet (
    .x (compNodes),
    .y (upClosure)
  );

  monotonizeNetwork #(
    .VARIABLES (VARIABLES),
    .DIRECTION (DIR_DOWN)
  ) downNet (
    .x (upClosure & topBound),
    .y (downClosure)
  );

  assign seedBit   = lowestSetBit(leftNodes);
  assign newNodes  = leftNodes & downClosure;
  assign remaining = leftNodes & ~newNodes;
  assign countNext = satIncrement(count, overflow);

  assign connectCountOut = count;
  assign overflowOut     = overflow;
  assign extraDataOut    = tag;

  // Job FSM with handshake flags registered alongside the state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      inReady   <= 1'b1;
      outValid  <= 1'b0;
      busy      <= 1'b0;
      leftNodes <= '0;
      compNodes <= '0;
      topBound  <= '0;
      tag       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (inValid) begin
            leftNodes <= graphIn;
            topBound  <= topIn;
            tag       <= extraDataIn;
            count     <= '0;
            overflow  <= 1'b0;
            inReady   <= 1'b0;
            busy      <= 1'b1;
            if (graphIn == '0) begin
              state    <= OUTPUT;
              outValid <= 1'b1;
            end else begin
              state    <= SEED;
            end
          end
        end
        SEED: begin
          compNodes           <= seedBit;
          leftNodes           <= leftNodes & ~seedBit;
          {overflow, count}   <= countNext;
          state               <= EXPAND;
        end
        EXPAND: begin
          if (newNodes != '0) begin
            compNodes <= compNodes | newNodes;
            leftNodes <= remaining;
            // Nothing left to seed: finish without a final empty expansion.
            if (remaining == '0) begin
              state    <= OUTPUT;
              outValid <= 1'b1;
            end
          end else if (leftNodes == '0) begin
            state    <= OUTPUT;
            outValid <= 1'b1;
          end else begin
            state    <= SEED;
          end
        end
        OUTPUT: begin
          if (outReady) begin
            state    <= IDLE;
            outValid <= 1'b0;
            busy     <= 1'b0;
            inReady  <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          outValid <= 1'b0;
          busy     <= 1'b0;
          inReady  <= 1'b1;
        end
      endcase
    end
  end

endmodule
